// File: rtl/bit_adder_pkg.sv
// rtl/bit_adder_pkg.sv - shared constants and helpers for the registered ripple-carry adder
//
// Purpose: default operand width, the legal width range, the carry-flag
// bundle registered by the top level, and the signed-overflow helper.
package bit_adder_pkg;

    localparam int BIT_ADDER_DEFAULT_WIDTH = 4;
    localparam int BIT_ADDER_MIN_WIDTH     = 2;
    localparam int BIT_ADDER_MAX_WIDTH     = 32;

    // Carry-visibility flags presented alongside the sum.
    typedef struct packed {
        logic cout;  // carry out of the MSB
        logic c3;    // carry into the MSB
        logic ovf;   // signed overflow
    } bit_adder_flags_t;

    // Signed overflow occurs exactly when the carry into the MSB differs from
    // the carry out of it.
    function automatic logic signed_ovf(input logic carry_out, input logic carry_msb);
        return carry_out ^ carry_msb;
    endfunction

    // Build the flag bundle from the two carry taps of the ripple chain.
    function automatic bit_adder_flags_t make_flags(input logic carry_out, input logic carry_msb);
        bit_adder_flags_t f;
        f.cout = carry_out;
        f.c3   = carry_msb;
        f.ovf  = signed_ovf(carry_out, carry_msb);
        return f;
    endfunction

endpackage

// File: rtl/bit_adder_full_adder.sv
// rtl/bit_adder_full_adder.sv - one-bit full adder cell of the ripple chain
//
// Purpose: purely combinational 1-bit full adder.
// Ports:
//   a, b  operand bits
//   ci    carry in
//   s     sum bit
//   co    carry out (majority of a, b, ci)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/bit_adder.sv
// rtl/bit_adder.sv - registered ripple-carry adder with carry and overflow visibility
//
// Purpose: adds two WIDTH-bit unsigned operands plus a carry-in through a
// chain of full_adder cells and registers sum, carry-out, carry into the MSB
// and signed overflow one clock after a qualified input.
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   IN_VALID   qualifies A, B, CIN this cycle
//   A, B       WIDTH-bit unsigned operands
//   CIN        carry into bit 0
//   S          registered sum, (A+B+CIN) mod 2^WIDTH
//   COUT       registered carry out of bit WIDTH-1
//   C3         registered carry into bit WIDTH-1
//   OVF        registered signed overflow, COUT ^ C3
//   OUT_VALID  one-cycle pulse marking a new result
module bit_adder
    import bit_adder_pkg::*;
#(
    parameter int WIDTH = BIT_ADDER_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             IN_VALID,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             CIN,
    output logic [WIDTH-1:0] S,
    output logic             COUT,
    output logic             C3,
    output logic             OVF,
    output logic             OUT_VALID
);

    localparam int MSB = WIDTH - 1;

    // Ripple chain: carry[i] is the carry into bit i; carry[WIDTH] leaves the MSB.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum;

    assign carry[0] = CIN;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (carry[i]),
            .s  (sum[i]),
            .co (carry[i+1])
        );
    end

    bit_adder_flags_t flags_now;
    assign flags_now = make_flags(carry[WIDTH], carry[MSB]);

    // Output registers and the valid flop.
    logic [WIDTH-1:0]  sum_q,   sum_d;
    bit_adder_flags_t  flags_q, flags_d;
    logic              valid_q, valid_d;

    // Result registers only load on a qualified input; otherwise they hold so
    // the last result stays visible after OUT_VALID drops.
    always_comb begin
        sum_d   = sum_q;
        flags_d = flags_q;
        valid_d = IN_VALID;
        if (IN_VALID) begin
            sum_d   = sum;
            flags_d = flags_now;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
        end else begin
            sum_q   <= sum_d;
            flags_q <= flags_d;
            valid_q <= valid_d;
        end
    end

    assign S         = sum_q;
    assign COUT      = flags_q.cout;
    assign C3        = flags_q.c3;
    assign OVF       = flags_q.ovf;
    assign OUT_VALID = valid_q;

endmodule

// File: tb/tb_bit_adder.sv
// tb/tb_bit_adder.sv - scoreboard bench for bit_adder at WIDTH=4
module tb_bit_adder;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         c3;
        logic         ovf;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        exp_t         e;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         cin = 1'b0;
    logic [W-1:0] s;
    logic         cout, c3, ovf, out_valid;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];
    exp_t last_exp;

    bit_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .IN_VALID  (in_valid),
        .A         (a),
        .B         (b),
        .CIN       (cin),
        .S         (s),
        .COUT      (cout),
        .C3        (c3),
        .OVF       (ovf),
        .OUT_VALID (out_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic chk_outputs(input string tag, input exp_t e, input logic want_valid);
        chk({tag, ".S"},         int'(s),         int'(e.s));
        chk({tag, ".COUT"},      int'(cout),      int'(e.cout));
        chk({tag, ".C3"},        int'(c3),        int'(e.c3));
        chk({tag, ".OVF"},       int'(ovf),       int'(e.ovf));
        chk({tag, ".OUT_VALID"}, int'(out_valid), int'(want_valid));
    endtask

    // Present one input for one edge; valid inputs push their expected result.
    task automatic apply(input vec_t v, input logic valid);
        a        = v.a;
        b        = v.b;
        cin      = v.cin;
        in_valid = valid;
        if (valid) exp_q.push_back(v.e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: pops on OUT_VALID, otherwise checks outputs hold the last result.
    always @(negedge clk) begin
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                last_exp = exp_q.pop_front();
                chk_outputs("result", last_exp, 1'b1);
            end
        end else begin
            chk_outputs("hold", last_exp, 1'b0);
        end
    end

    vec_t vecs[10];
    vec_t idle_v;
    vec_t rst_v;
    exp_t zero_e;

    initial begin
        zero_e = '{s: 4'd0, cout: 1'b0, c3: 1'b0, ovf: 1'b0};
        last_exp = zero_e;
        //          a      b      cin     s       cout  c3    ovf
        vecs[0] = '{4'd4,  4'd2,  1'b0, '{4'd6,  1'b0, 1'b0, 1'b0}};
        vecs[1] = '{4'd9,  4'd7,  1'b1, '{4'd1,  1'b1, 1'b1, 1'b0}};
        vecs[2] = '{4'd7,  4'd1,  1'b0, '{4'd8,  1'b0, 1'b1, 1'b1}};
        vecs[3] = '{4'd8,  4'd8,  1'b0, '{4'd0,  1'b1, 1'b0, 1'b1}};
        vecs[4] = '{4'd15, 4'd15, 1'b1, '{4'd15, 1'b1, 1'b1, 1'b0}};
        vecs[5] = '{4'd3,  4'd4,  1'b0, '{4'd7,  1'b0, 1'b0, 1'b0}};
        vecs[6] = '{4'd5,  4'd5,  1'b1, '{4'd11, 1'b0, 1'b1, 1'b1}};
        vecs[7] = '{4'd0,  4'd0,  1'b0, '{4'd0,  1'b0, 1'b0, 1'b0}};
        vecs[8] = '{4'd9,  4'd7,  1'b1, '{4'd1,  1'b1, 1'b1, 1'b0}};
        vecs[9] = '{4'd2,  4'd3,  1'b0, '{4'd5,  1'b0, 1'b0, 1'b0}};
        idle_v  = '{4'd1,  4'd1,  1'b0, zero_e};
        rst_v   = '{4'd5,  4'd5,  1'b1, zero_e};

        // Power-on reset, checked between edges.
        #1 rst_n = 1'b0;
        #1 chk_outputs("reset", zero_e, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Isolated adds with idle cycles between them.
        for (int i = 0; i < 5; i++) begin
            apply(vecs[i], 1'b1);
            apply(idle_v, 1'b0);
        end
        // Extra idle with A=B=1: outputs must stay at 15/1/1/0.
        apply(idle_v, 1'b0);

        // Back-to-back valid inputs.
        for (int i = 5; i < 8; i++) apply(vecs[i], 1'b1);
        apply(idle_v, 1'b0);

        // Mid-cycle reset while outputs are non-zero; the pending input is discarded.
        apply(vecs[8], 1'b1);
        a = rst_v.a; b = rst_v.b; cin = rst_v.cin; in_valid = 1'b1;
        #1;
        rst_n = 1'b0;
        last_exp = zero_e;
        exp_q.delete();
        #1 chk_outputs("async_reset", zero_e, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        apply(vecs[9], 1'b1);
        apply(idle_v, 1'b0);

        // Drain: every pushed expectation must have been observed.
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/bit_adder.md
# bit_adder

Registered ripple-carry adder: adds two WIDTH-bit unsigned operands plus a carry-in and presents sum, carry-out, carry into the MSB and a signed-overflow flag one clock after a valid input. It is a leaf arithmetic block used wherever a small clocked add with carry visibility is needed, for example when cascading adders or detecting signed overflow.

## Interface
- WIDTH, default 4: operand and sum width; legal range 2 to 32.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- IN_VALID  input  1  qualifies A, B and CIN for this cycle.
- A  input  WIDTH  operand A, unsigned.
- B  input  WIDTH  operand B, unsigned.
- CIN  input  1  carry into bit 0.
- S  output  WIDTH  registered sum bits, (A+B+CIN) mod 2^WIDTH.
- COUT  output  1  registered carry out of bit WIDTH-1.
- C3  output  1  registered carry into bit WIDTH-1 (carry out of bit WIDTH-2). It is named C3 because the default WIDTH is 4.
- OVF  output  1  registered signed overflow, COUT XOR C3.
- OUT_VALID  output  1  high for one cycle when S, COUT, C3 and OVF carry a new result.

## Operation
- Combinational chain of WIDTH one-bit full adders.
  - c[0] = CIN.
  - s[i] = A[i] ^ B[i] ^ c[i].
  - c[i+1] = A[i]&B[i] | A[i]&c[i] | B[i]&c[i].
- On a rising edge with IN_VALID=1:
  - S <= s, COUT <= c[WIDTH], C3 <= c[WIDTH-1], OVF <= c[WIDTH] ^ c[WIDTH-1].
  - OUT_VALID <= 1.
- On a rising edge with IN_VALID=0:
  - S, COUT, C3 and OVF hold their previous values.
  - OUT_VALID <= 0.
- There is no backpressure. A new valid input is accepted every cycle, and back-to-back results appear on consecutive cycles.
- Arithmetic width rules:
  - The full result {COUT,S} is WIDTH+1 bits and equals A+B+CIN exactly.
  - No saturation; S wraps modulo 2^WIDTH.
- Only the ripple chain is combinational; all outputs are registered.

## Timing
- Latency: result for the inputs sampled at edge n is visible after edge n. OUT_VALID is high from edge n until edge n+1.
- Reset values while rst_n=0 (asserted asynchronously, independent of clk): S=0, COUT=0, C3=0, OVF=0, OUT_VALID=0.
- Reset asserted mid-operation discards any in-flight result. No OUT_VALID is produced for the input sampled in the cycle reset is asserted.
- Release of rst_n is synchronous to operation. The first edge with rst_n=1 and IN_VALID=1 produces a result.
- Boundary conditions:
  - All-ones + all-ones + 1 gives S = all-ones, COUT=1, C3=1, OVF=0.
  - 0 + 0 + 0 gives all-zero outputs with OUT_VALID=1.

## Structure
- Sub-module full_adder: 1-bit inputs a, b, ci; outputs s, co. Instantiate WIDTH copies in a generate loop.
- Shared package bit_adder_pkg:
  - BIT_ADDER_DEFAULT_WIDTH = 4.
  - Localparam MSB = WIDTH-1, used for the C3 tap.
- Top level holds the generate chain, the output registers and the valid flop.

## Test plan
- WIDTH=4, reset, then A=4, B=2, CIN=0 with IN_VALID=1 -> next edge: S=6, COUT=0, C3=0, OVF=0, OUT_VALID=1.
- A=9, B=7, CIN=1 -> S=1, COUT=1, C3=1, OVF=0.
- A=7, B=1, CIN=0 -> S=8, COUT=0, C3=1, OVF=1. A=8, B=8, CIN=0 -> S=0, COUT=1, C3=0, OVF=1.
- A=15, B=15, CIN=1 -> S=15, COUT=1, C3=1, OVF=0. Then IN_VALID=0 with A=1, B=1 -> outputs hold 15/1/1/0 and OUT_VALID=0.
- Drive valid inputs every cycle (3+4, 5+5+1, 0+0) -> results 7, 11, 0 on three consecutive edges, each with OUT_VALID=1.
- Assert rst_n=0 between clock edges while outputs are non-zero -> all outputs 0 immediately. Release and apply A=2, B=3, CIN=0 -> S=5 one edge later.
